// File: rtl/hash_check_pkg.sv
// Shared types, FSM states and helpers for the hash checker and its target decoder.
package hash_check_pkg;

  typedef logic [255:0] hash_t;
  typedef logic [31:0]  difficulty_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } check_state_t;

  localparam hash_t TARGET_MAX = '1;

  // Exponents above this value push every mantissa bit past bit 255.
  localparam logic [7:0] EXP_SATURATE = 8'd34;
  localparam logic [7:0] EXP_UNITY    = 8'd3;

  // Reverses byte order so that byte 0 of the SHA output becomes the most significant byte.
  function automatic hash_t byte_swap(input hash_t h);
    hash_t r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = h[8*(31-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hash_checker_if.sv
// Result-stream bus between the SHA core and the hash checker, plus the checker's status outputs.
interface hash_checker_if #(
  parameter int COUNTBITS = 6
);
  import hash_check_pkg::*;

  logic                 validIn;
  logic                 newBlockIn;
  hash_t                hash;
  difficulty_t          difficulty;
  logic                 success;
  logic                 found;
  logic                 exhausted;
  logic [COUNTBITS-1:0] nonce;
  logic [COUNTBITS-1:0] resultCount;

  modport master (
    output validIn, newBlockIn, hash, difficulty,
    input  success, found, exhausted, nonce, resultCount
  );

  modport slave (
    input  validIn, newBlockIn, hash, difficulty,
    output success, found, exhausted, nonce, resultCount
  );

endinterface

// File: rtl/hash_target_decode.sv
// Expands a compact difficulty word (exponent E, mantissa M) into the full 256-bit target.
module hash_target_decode
  import hash_check_pkg::*;
(
  input  difficulty_t difficulty,
  output hash_t       target
);

  logic [7:0] exponent;
  hash_t      mantissa;

  assign exponent = difficulty[31:24];
  assign mantissa = {232'd0, difficulty[23:0]};

  // Shift counts are whole bytes; bits pushed past either end are simply dropped.
  always_comb begin
    target = '0;
    if (exponent > EXP_SATURATE) begin
      target = TARGET_MAX;
    end else if (exponent >= EXP_UNITY) begin
      target = mantissa << {exponent - EXP_UNITY, 3'b000};
    end else begin
      target = mantissa >> {EXP_UNITY - exponent, 3'b000};
    end
  end

endmodule

// File: rtl/hash_checker.sv
// Checks each SHA result against the difficulty target and tracks the first winning index per block.
// Define HASH_CHECK_BYTESWAP_EN to byte-reverse the hash (Bitcoin order) before the compare.
module hash_checker
  import hash_check_pkg::*;
#(
  parameter int COUNTBITS = 6
)
(
  input logic           clk,
  input logic           rst,
  hash_checker_if.slave bus
);

  localparam logic [COUNTBITS-1:0] LAST_INDEX = '1;
  localparam logic [COUNTBITS-1:0] FIRST_NEXT = COUNTBITS'(1);

  check_state_t         state;
  logic                 success_q;
  logic                 found_q;
  logic                 exhausted_q;
  logic [COUNTBITS-1:0] nonce_q;
  logic [COUNTBITS-1:0] result_count;

  hash_t target;
  hash_t hash_cmp;
  logic  pass;
  logic  new_block;
  logic  search_beat;

  hash_target_decode u_decode (
    .difficulty (bus.difficulty),
    .target     (target)
  );

`ifdef HASH_CHECK_BYTESWAP_EN
  assign hash_cmp = byte_swap(bus.hash);
`else
  assign hash_cmp = bus.hash;
`endif

  assign pass        = (hash_cmp <= target);
  assign new_block   = bus.validIn && bus.newBlockIn;
  assign search_beat = bus.validIn && (state == SEARCH);

  // A new-block beat wins over everything but reset, whatever state the block was in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      success_q    <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      nonce_q      <= '0;
      result_count <= '0;
    end else begin
      success_q <= 1'b0;
      if (new_block) begin
        exhausted_q  <= 1'b0;
        result_count <= FIRST_NEXT;
        if (pass) begin
          success_q <= 1'b1;
          found_q   <= 1'b1;
          nonce_q   <= '0;
          state     <= FOUND;
        end else begin
          found_q <= 1'b0;
          state   <= SEARCH;
        end
      end else if (search_beat) begin
        // Incrementing past the last index wraps the counter to zero on exhaustion.
        result_count <= result_count + FIRST_NEXT;
        if (pass) begin
          success_q <= 1'b1;
          found_q   <= 1'b1;
          nonce_q   <= result_count;
          state     <= FOUND;
        end else if (result_count == LAST_INDEX) begin
          exhausted_q <= 1'b1;
          state       <= EXHAUSTED;
        end
      end
    end
  end

  assign bus.success     = success_q;
  assign bus.found       = found_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.nonce       = nonce_q;
  assign bus.resultCount = result_count;

endmodule

// File: doc/hash_checker.md
Name: hash_checker

Overview:
- Consumes the SHA core result stream (validIn, newBlockIn, hash, difficulty) and decides whether each hash meets the target encoded by the compact difficulty word.
- Tracks the result index within the current block and latches the first winning index.
- Reports an exhausted block when every index fails.
- Sits directly downstream of the SHA core or its dummy stand-in, and feeds the host-facing result logic.

Parameters:
- COUNTBITS, 6, width of the per-block result index; a block holds 2^COUNTBITS results.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- validIn  input  1  hash/difficulty/newBlockIn valid this cycle
- newBlockIn  input  1  qualified by validIn; this beat is result index 0 of a new block
- hash  input  256  hash result, bit 255 most significant
- difficulty  input  32  compact target: [31:24] exponent E, [23:0] mantissa M
- success  output  1  one-cycle pulse when the first winning hash of a block is found
- found  output  1  level; a winner has been latched for the current block
- exhausted  output  1  level; all 2^COUNTBITS results failed
- nonce  output  COUNTBITS  index of the winning result, valid while found=1
- resultCount  output  COUNTBITS  index of the next expected result in the block

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high and beats every other input in the same cycle.
- Reset values: state=IDLE; success=0, found=0, exhausted=0, nonce=0, resultCount=0.
- Target decode, combinational: target = M << 8*(E-3) for E>=3, and M >> 8*(3-E) for E<3. Compute in 256 bits; bits shifted out are lost. If E>34, target = all ones.
- Pass rule: a beat passes iff hash <= target, as a 256-bit unsigned compare.
- Latency: outputs are registered and update in the cycle after the qualifying validIn beat.
- States:
  - IDLE: validIn without newBlockIn is ignored. validIn&newBlockIn evaluates index 0, then goes to SEARCH, or to FOUND if the beat passes.
  - SEARCH: each validIn beat takes index resultCount, then resultCount increments.
    - A passing beat sets nonce=index, pulses success, sets found=1 and goes to FOUND.
    - A failing beat at index 2^COUNTBITS-1 sets exhausted=1, wraps resultCount to 0 and goes to EXHAUSTED.
  - FOUND and EXHAUSTED: plain validIn beats are ignored, and resultCount freezes.
- New block in any state: validIn&newBlockIn restarts the block.
  - Clears found and exhausted, sets index=0 and resultCount=1, and evaluates the beat normally.
  - If that beat passes, success pulses again and nonce=0.
- newBlockIn without validIn: no effect.
- success is high for exactly one cycle per block.
- When FOUND is entered and a new block starts on the very next beat, found goes 1 then is cleared and re-evaluated. No cycle is skipped.
- Reset mid-block: all state is discarded. The next block must begin with newBlockIn.

Optional Feature:
- HASH_CHECK_BYTESWAP_EN
  - Defined: hash is byte-reversed before the compare, so byte 0 (bits 7:0) becomes the most significant byte. This matches Bitcoin's little-endian hash order.
  - Undefined: hash is compared as presented.
- Ports and latency are identical in both builds.

Decomposition:
- Package hash_check_pkg holds:
  - typedefs hash_t (256 bits) and difficulty_t (32 bits);
  - enum check_state_t {IDLE, SEARCH, FOUND, EXHAUSTED};
  - constant TARGET_MAX (all ones).
- One sub-module, hash_target_decode: combinational difficulty_t to hash_t target expansion, including the E<3 and E>34 cases. It can be tested standalone.

Test Plan:
- difficulty=0x1d00ffff, newBlock beat with hash=0 -> one cycle later success=1, found=1, nonce=0; success=0 on the following cycle.
- difficulty=0x1d00ffff, hash=all ones for indices 0..4, then hash=0 at index 5 -> success at index 5 with nonce=5. Later beats are ignored and resultCount stays 6.
- COUNTBITS=2, difficulty=0x03000001 (target=1), four beats of hash=2 -> exhausted=1 after the 4th, found=0, resultCount=0.
- While in FOUND, validIn&newBlockIn with hash=all ones -> found=0, exhausted=0, resultCount=1, state SEARCH.
- difficulty exponent edges: E=0x02, M=0x000100 gives target=1, so hash=1 passes and hash=2 fails; E=0x23 gives all ones, so hash=all ones passes.
- rst asserted on the same cycle as a passing validIn beat -> no success pulse and all outputs 0. Then plain validIn in IDLE -> no response.
